// File: rtl/timebase_pkg.sv
// Shared constants and elaboration helpers for the alarm-clock timebase.
package timebase_pkg;

  localparam int unsigned CS_PER_SEC     = 100;
  localparam int unsigned SEC_PER_MIN    = 60;
  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned base_hz);
    if (base_hz == 32'd0) begin
      return 32'd0;
    end else begin
      return clk_hz / base_hz;
    end
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timebase_gen_mod_counter.sv
// Modulo-MOD up-counter with clock enable, synchronous clear and a same-cycle wrap flag.
module mod_counter
  import timebase_pkg::*;
#(
  parameter int unsigned MOD = 100,
  parameter int unsigned W   = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 32'd1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  // Next count: clear dominates, then wrap to zero, then increment when enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timebase_gen.sv
// Timebase: prescaler producing centisecond/second/minute one-cycle enables,
// binary cs/sec counts and a cs-rate square wave. All outputs registered.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
  parameter int unsigned BASE_HZ   = 100,
  parameter int unsigned FAST_MULT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic       fast,
  output logic       cs_tick,
  output logic       sec_tick,
  output logic       min_tick,
  output logic [6:0] cs_count,
  output logic [5:0] sec_count,
  output logic       cs_clk
);

  localparam int unsigned DIV      = div_of(CLK_HZ, BASE_HZ);
  localparam int unsigned DIV_FAST = (FAST_MULT == 32'd0) ? 32'd0 : DIV / FAST_MULT;
  localparam int unsigned CW       = (clog2(DIV) < 32'd1) ? 32'd1 : clog2(DIV);
  localparam logic [CW-1:0] TC_M1_NORM = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] TC_M1_FAST = CW'(DIV_FAST - 32'd1);

  if (BASE_HZ == 32'd0 || (CLK_HZ % BASE_HZ) != 32'd0) begin : g_err_ratio
    $error("timebase_gen: CLK_HZ must be a nonzero multiple of BASE_HZ");
  end
  if (DIV < 32'd2) begin : g_err_div
    $error("timebase_gen: CLK_HZ/BASE_HZ must be at least 2");
  end
  if (DIV_FAST < 32'd1) begin : g_err_fast
    $error("timebase_gen: DIV/FAST_MULT must be at least 1");
  end

  logic [CW-1:0] pre_q, pre_d, tc_m1_s;
  logic          tick_s, cs_wrap_s, sec_wrap_s;
  logic          cs_tick_q, sec_tick_q, min_tick_q, cs_clk_q;
  logic          cs_clk_d;

  // Prescaler: the >= compare forces a wrap when fast lowers the terminal count below pre.
  always_comb begin
    tc_m1_s = TC_M1_NORM;
    if (fast) begin
      tc_m1_s = TC_M1_FAST;
    end else begin
      tc_m1_s = TC_M1_NORM;
    end
    tick_s = run && !clear && (pre_q >= tc_m1_s);
    pre_d  = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (!run) begin
      pre_d = pre_q;
    end else if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + CW'(1);
    end
    cs_clk_d = cs_clk_q;
    if (clear) begin
      cs_clk_d = 1'b0;
    end else if (tick_s) begin
      cs_clk_d = ~cs_clk_q;
    end else begin
      cs_clk_d = cs_clk_q;
    end
  end

  mod_counter #(.MOD(CS_PER_SEC)) u_cs_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_s),
    .clr   (clear),
    .count (cs_count),
    .wrap  (cs_wrap_s)
  );

  mod_counter #(.MOD(SEC_PER_MIN)) u_sec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cs_wrap_s),
    .clr   (clear),
    .count (sec_count),
    .wrap  (sec_wrap_s)
  );

  // Prescaler, tick pulses and square-wave registers; ticks drop whenever no wrap occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      cs_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      cs_clk_q   <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      cs_tick_q  <= tick_s;
      sec_tick_q <= cs_wrap_s;
      min_tick_q <= sec_wrap_s;
      cs_clk_q   <= cs_clk_d;
    end
  end

  assign cs_tick  = cs_tick_q;
  assign sec_tick = sec_tick_q;
  assign min_tick = min_tick_q;
  assign cs_clk   = cs_clk_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen: tick-count model compared every cycle plus directed literals.
module tb_timebase_gen;

  localparam int DIV     = 10;  // 1000 Hz / 100 Hz
  localparam int FAST_TC = 2;   // 10 / 5

  logic       clk, rst_n, run, clear, fast;
  logic       cs_tick, sec_tick, min_tick, cs_clk;
  logic [6:0] cs_count;
  logic [5:0] sec_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase within the current period and total cs ticks since reset/clear.
  int          m_ph = 0;
  int unsigned m_n  = 0;
  bit          m_tk = 1'b0;

  timebase_gen #(.CLK_HZ(1000), .BASE_HZ(100), .FAST_MULT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .clear     (clear),
    .fast      (fast),
    .cs_tick   (cs_tick),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick),
    .cs_count  (cs_count),
    .sec_count (sec_count),
    .cs_clk    (cs_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n || clear) begin
      m_ph = 0;
      m_n  = 0;
      m_tk = 1'b0;
    end else if (run) begin
      if (m_ph >= (fast ? FAST_TC : DIV) - 1) begin
        m_ph = 0;
        m_n++;
        m_tk = 1'b1;
      end else begin
        m_ph++;
        m_tk = 1'b0;
      end
    end else begin
      m_tk = 1'b0;
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {15'd0, cs_tick, sec_tick, min_tick, cs_count, sec_count, cs_clk};
  endfunction

  function automatic logic [31:0] model_vec();
    logic       e_sec, e_min, e_clk;
    logic [6:0] e_cs;
    logic [5:0] e_sec_cnt;
    e_cs      = 7'(m_n % 100);
    e_sec_cnt = 6'((m_n / 100) % 60);
    e_sec     = m_tk && (m_n % 100 == 0);
    e_min     = m_tk && (m_n % 6000 == 0);
    e_clk     = 1'(m_n % 2);
    return {15'd0, m_tk, e_sec, e_min, e_cs, e_sec_cnt, e_clk};
  endfunction

  // Per-cycle compare against the model.
  always begin
    @(posedge clk);
    model_step();
    #1;
    check("cycle_outputs", dut_vec(), model_vec());
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; fast = 1'b0;
    wait_edges(2);
    check("reset_state", dut_vec(), 32'd0);

    // Normal counting: ticks at 10, 20.
    rst_n = 1'b1; run = 1'b1;
    wait_edges(9);  check("tick_before_tc", 32'(cs_tick), 32'd0);
    wait_edges(1);  check("first_tick", 32'(cs_tick), 32'd1);
    check("first_cs_count", 32'(cs_count), 32'd1);
    check("first_cs_clk", 32'(cs_clk), 32'd1);
    wait_edges(1);  check("tick_width", 32'(cs_tick), 32'd0);
    wait_edges(9);  check("second_tick", 32'(cs_tick), 32'd1);
    check("second_cs_clk", 32'(cs_clk), 32'd0);

    // Pause 7 cycles at pre=4: next tick 7 cycles late.
    wait_edges(4);  run = 1'b0;
    wait_edges(7);
    check("pause_cs_count", 32'(cs_count), 32'd2);
    check("pause_cs_clk", 32'(cs_clk), 32'd0);
    run = 1'b1;
    wait_edges(5);  check("resume_no_tick", 32'(cs_tick), 32'd0);
    wait_edges(1);  check("resume_tick", 32'(cs_tick), 32'd1);
    check("resume_cs_count", 32'(cs_count), 32'd3);

    // Fast asserted at pre=7: wrap on next edge, then period 2.
    wait_edges(7);  fast = 1'b1;
    wait_edges(1);  check("fast_wrap", 32'(cs_tick), 32'd1);
    check("fast_wrap_count", 32'(cs_count), 32'd4);
    wait_edges(1);  check("fast_gap", 32'(cs_tick), 32'd0);
    wait_edges(1);  check("fast_period", 32'(cs_count), 32'd5);

    // Reach cs=57, sec=12 in fast mode, then clear with run high.
    clear = 1'b1;
    wait_edges(1);  clear = 1'b0;
    wait_edges(2 * 1257);
    check("pre_clear_cs", 32'(cs_count), 32'd57);
    check("pre_clear_sec", 32'(sec_count), 32'd12);
    clear = 1'b1; fast = 1'b0;
    wait_edges(1);  check("clear_wins", dut_vec(), 32'd0);
    clear = 1'b0;
    wait_edges(9);  check("post_clear_quiet", 32'(cs_tick), 32'd0);
    wait_edges(1);  check("post_clear_tick", 32'(cs_tick), 32'd1);

    // Second and minute wraps in fast mode.
    clear = 1'b1; fast = 1'b1;
    wait_edges(1);  clear = 1'b0;
    wait_edges(2 * 99);
    check("cs_99", 32'(cs_count), 32'd99);
    check("no_sec_tick_yet", 32'(sec_tick), 32'd0);
    wait_edges(2);
    check("sec_tick_wrap", {29'd0, cs_tick, sec_tick, 1'b0}, 32'd6);
    check("sec_count_1", 32'(sec_count), 32'd1);
    wait_edges(2 * 5899);
    check("sec_59", 32'(sec_count), 32'd59);
    check("no_min_tick_yet", 32'(min_tick), 32'd0);
    wait_edges(2);
    check("min_tick_wrap", {29'd0, sec_tick, min_tick, 1'b0}, 32'd6);
    check("min_wrap_counts", {25'd0, cs_count}, 32'd0);

    // Async reset between edges.
    fast = 1'b0;
    wait_edges(13);
    check("pre_reset_cs", 32'(cs_count), 32'd1);
    check("pre_reset_clk", 32'(cs_clk), 32'd1);
    #3 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), 32'd0);
    wait_edges(2);  rst_n = 1'b1;
    wait_edges(10); check("tick_after_reset", 32'(cs_tick), 32'd1);
    wait_edges(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
